branch_resolve: RTL
===================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk` (input, 1, rising-edge clock) and `rst_n` (input, 1, asynchronous active-low reset).
REQ-002 Parameter `DEPTH`, default 4, SHALL set the number of outstanding-prediction entries (power of two, 2..16).
REQ-003 `push` (input, 1) SHALL mean fetch issued a branch and its prediction this cycle.
REQ-004 `pushPC` (input, 10) SHALL carry the PC of the branch being pushed.
REQ-005 `pushTaken` (input, 1) SHALL carry the predicted direction.
REQ-006 `pushTarget` (input, 10) SHALL carry the predicted taken target.
REQ-007 `resolve` (input, 1) SHALL mean execute resolved the oldest outstanding branch this cycle.
REQ-008 `actTaken` (input, 1) SHALL carry the actual direction.
REQ-009 `actTarget` (input, 10) SHALL carry the actual taken target.
REQ-010 `full` (output, 1) SHALL indicate no free entry; fetch stalls branch issue while it is high.
REQ-011 `predRW` (output, 1) SHALL be a one-cycle misprediction pulse that redirects InstructionFetch.
REQ-012 `PCnext` (output, 10) SHALL carry the corrected PC; it is valid when `predRW` is high.
REQ-013 `flushing` (output, 1) SHALL be high while the block is discarding wrong-path state.
REQ-014 `mispredCnt` (output, 16) SHALL be a saturating count of mispredictions.

Function
REQ-015 Each entry SHALL store {PC[9:0], taken, target[9:0]} in a circular FIFO with read/write pointers and a count of width log2(DEPTH)+1.
REQ-016 A push SHALL be accepted when `push` is high, `full` is low, and the state is RUN; a push while `full` is high SHALL be dropped with no state change.
REQ-017 A resolve SHALL compare the head entry against `actTaken`/`actTarget` in the same cycle. The branch mispredicts if the direction differs, or if both are taken and the targets differ.
REQ-018 On a mispredict, `predRW` SHALL be registered high in the next cycle, with `PCnext` = `actTarget` if `actTaken` else head PC+1 (mod 1024, so 1023+1 = 0).
REQ-019 On a correct prediction, the head entry SHALL be popped and `predRW` SHALL stay low.
REQ-020 The state machine SHALL have states RUN and FLUSH.
REQ-021 RUN SHALL go to FLUSH on a mispredict. That mispredict SHALL empty the FIFO (pointers and count cleared) and load a 2-bit flush counter with 2.
REQ-022 In FLUSH, pushes and resolves SHALL be ignored and the counter SHALL decrement each cycle; at 0 the state SHALL return to RUN. `flushing` SHALL equal (state == FLUSH).
REQ-023 A simultaneous push and correct resolve SHALL pop and push in the same cycle, leaving the count unchanged; this SHALL be legal even when `full` is high.
REQ-024 A simultaneous push and mispredicting resolve SHALL discard the push.
REQ-025 A resolve while the FIFO is empty SHALL be ignored: no pop, no `predRW`.
REQ-026 `mispredCnt` SHALL increment on each mispredict and hold at 16'hFFFF.
REQ-027 `full` SHALL equal (count == DEPTH) and be derived combinationally from registered count.
REQ-028 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 While `rst_n` is low, the block SHALL asynchronously clear: state = RUN, FIFO empty, flush counter = 0, `predRW` = 0, `PCnext` = 0, `mispredCnt` = 0.
REQ-030 A reset asserted mid-FLUSH or with entries pending SHALL discard all of them; after release, the first rising edge SHALL accept pushes.

Structure
REQ-031 A shared package SHALL hold PC_W = 10, the branch-entry struct, and the state enum; InstructionFetch SHALL use the same PC_W.
REQ-032 The FIFO SHALL be one sub-module `pred_fifo` (push, pop, clear, full, empty, head), instanced once.

Verification
REQ-033 Push PC=5, taken=1, target=24, then resolve actTaken=1, actTarget=24 -> `predRW` stays 0 and the FIFO is empty.
REQ-034 Push PC=5, taken=0, then resolve actTaken=1, actTarget=24 -> the next cycle shows `predRW` = 1 and `PCnext` = 24; `flushing` is high for 2 cycles; `mispredCnt` = 1.
REQ-035 Push PC=1023, taken=1, target=7, then resolve actTaken=0 -> `PCnext` = 0 (wrap).
REQ-036 Push 4 entries (DEPTH=4) -> `full` = 1; a 5th push is dropped; a push plus correct resolve in the same cycle keeps `full` = 1 with the new entry at the tail.
REQ-037 Push during FLUSH and resolve on an empty FIFO -> both ignored, no `predRW`.
REQ-038 Assert `rst_n` = 0 mid-FLUSH with `mispredCnt` = 3 -> all outputs read 0 immediately (before the next clock edge), and state returns to RUN.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared PC width, prediction entry and resolver state types
package branch_resolve_pkg;

   localparam int PC_W = 10;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            taken;
      logic [PC_W-1:0] target;
   } br_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } br_state_t;

   // Fall-through PC; wraps naturally at the PC width.
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + PC_W'(1);
   endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - fetch/execute side signals of the branch resolver
interface branch_resolve_if;
   import branch_resolve_pkg::*;

   logic            push;
   logic [PC_W-1:0] pushPC;
   logic            pushTaken;
   logic [PC_W-1:0] pushTarget;
   logic            resolve;
   logic            actTaken;
   logic [PC_W-1:0] actTarget;
   logic            full;
   logic            predRW;
   logic [PC_W-1:0] PCnext;
   logic            flushing;
   logic [15:0]     mispredCnt;

   modport master (
      output push, pushPC, pushTaken, pushTarget, resolve, actTaken, actTarget,
      input  full, predRW, PCnext, flushing, mispredCnt
   );

   modport slave (
      input  push, pushPC, pushTaken, pushTarget, resolve, actTaken, actTarget,
      output full, predRW, PCnext, flushing, mispredCnt
   );

endinterface

// File: rtl/branch_resolve_pred_fifo.sv
// rtl/branch_resolve_pred_fifo.sv - circular FIFO of outstanding branch predictions
module pred_fifo
   import branch_resolve_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  logic      clear,
   input  br_entry_t din,
   output logic      full,
   output logic      empty,
   output br_entry_t head
);

   localparam int AW = $clog2(DEPTH);

   br_entry_t       mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     count;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Push into a full FIFO is only issued alongside a pop; the head is read before being overwritten.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - checks fetch predictions against execute outcomes, redirects and flushes
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   branch_resolve_if.slave   bus
);

   br_state_t       state, state_nx;
   logic [1:0]      flush_cnt, flush_cnt_nx;
   logic            pred_rw;
   logic [PC_W-1:0] pc_next;
   logic [15:0]     mispred_cnt;

   logic            mispred;
   logic            pop;
   logic            push_ok;
   logic            fifo_full;
   logic            fifo_empty;
   br_entry_t       head;
   br_entry_t       din;
   logic [PC_W-1:0] redirect_pc;

   assign din = '{pc: bus.pushPC, taken: bus.pushTaken, target: bus.pushTarget};

   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_ok),
      .pop   (pop),
      .clear (mispred),
      .din   (din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

   assign redirect_pc = bus.actTaken ? bus.actTarget : pc_inc(head.pc);

   always_comb begin
      state_nx     = state;
      flush_cnt_nx = flush_cnt;
      mispred      = 1'b0;
      pop          = 1'b0;
      push_ok      = 1'b0;
      case (state)
         RUN: begin
            if (bus.resolve && !fifo_empty) begin
               if ((head.taken != bus.actTaken) ||
                   (head.taken && bus.actTaken && (head.target != bus.actTarget)))
                  mispred = 1'b1;
               else
                  pop = 1'b1;
            end
            // A correct resolve frees the head slot, so a full FIFO can still take the push.
            push_ok = bus.push && !mispred && (!fifo_full || pop);
            if (mispred) begin
               state_nx     = FLUSH;
               flush_cnt_nx = 2'd2;
            end
         end
         FLUSH: begin
            flush_cnt_nx = flush_cnt - 2'd1;
            if (flush_cnt <= 2'd1) state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         flush_cnt   <= 2'd0;
         pred_rw     <= 1'b0;
         pc_next     <= '0;
         mispred_cnt <= 16'd0;
      end else begin
         state     <= state_nx;
         flush_cnt <= flush_cnt_nx;
         pred_rw   <= mispred;
         if (mispred) begin
            pc_next <= redirect_pc;
            if (mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
         end
      end
   end

   assign bus.full       = fifo_full;
   assign bus.predRW     = pred_rw;
   assign bus.PCnext     = pc_next;
   assign bus.flushing   = (state == FLUSH);
   assign bus.mispredCnt = mispred_cnt;

endmodule
